// File: rtl/da_lut_loader.sv
// Write-side master for the sram_8blk distributed-arithmetic LUT: walks each block in Gray-code
// order, accumulates partial sums incrementally and streams them out. Optional: `LUT_CHECKSUM_EN.
module da_lut_loader #(
    parameter int CW   = 16,
    parameter int DW   = 20,
    parameter int NBLK = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          coef_we,
    input  logic [5:0]    coef_idx,
    input  logic [CW-1:0] coef_din,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] sram_d,
    output logic [10:0]   sram_caddr,
    output logic          sram_wen,
    output logic          sram_cen
`ifdef LUT_CHECKSUM_EN
    ,
    output logic [DW-1:0] checksum
`endif
);

    // ARM is the single cycle between sampling start and presenting the first entry.
    typedef enum logic [1:0] {IDLE, ARM, LOAD, FLUSH} state_t;

    state_t        state;
    logic [CW-1:0] coef [64];
    logic [2:0]    blk;
    logic [7:0]    n;
    logic [DW-1:0] acc;
    logic          last_sent;
    logic          start_armed;

    logic [7:0]    n_inc;
    logic [7:0]    gray_cur;
    logic [7:0]    gray_inc;
    logic [2:0]    tz;
    logic [CW-1:0] coef_sel;
    logic [DW-1:0] coef_ext;
    logic [DW-1:0] acc_step;

    // Step n -> n+1 flips exactly one Gray bit (the trailing-zero position of n+1),
    // so one add or subtract moves acc to the next LUT word.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        n_inc    = n + 8'd1;
        gray_cur = n ^ (n >> 1);
        gray_inc = n_inc ^ (n_inc >> 1);
        tz       = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (n_inc[i]) tz = 3'(i);
        end
        coef_sel = coef[{blk, tz}];
        coef_ext = {{(DW-CW){coef_sel[CW-1]}}, coef_sel};
        acc_step = gray_inc[tz] ? (acc + coef_ext) : (acc - coef_ext);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            sram_d      <= '0;
            sram_caddr  <= '0;
            sram_wen    <= 1'b1;
            sram_cen    <= 1'b1;
            blk         <= '0;
            n           <= '0;
            acc         <= '0;
            last_sent   <= 1'b0;
            start_armed <= 1'b1;
            // NOTE: the coefficient bank is reset, so a load before any write yields all-zero words.
            for (int i = 0; i < 64; i++) coef[i] <= '0;
`ifdef LUT_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            // NOTE: all state here uses non-blocking assignment so every register sees pre-edge values.
            done <= 1'b0;
            if (!start) start_armed <= 1'b1;
            case (state)
                IDLE: begin
                    if (coef_we) coef[coef_idx] <= coef_din;
                    if (start && start_armed) begin
                        state       <= ARM;
                        start_armed <= 1'b0;
                        blk         <= '0;
                        n           <= '0;
                        acc         <= '0;
                        last_sent   <= 1'b0;
`ifdef LUT_CHECKSUM_EN
                        checksum    <= '0;
`endif
                    end
                end
                ARM, LOAD: begin
                    if (state == LOAD && last_sent) begin
                        state <= FLUSH;
                    end else begin
                        state      <= LOAD;
                        busy       <= 1'b1;
                        sram_cen   <= 1'b0;
                        // The SRAM registers caddr/d, so the write strobe trails them by a cycle.
                        sram_wen   <= (state == ARM);
                        sram_caddr <= {blk, gray_cur};
                        sram_d     <= acc;
`ifdef LUT_CHECKSUM_EN
                        checksum   <= checksum + acc;
`endif
                        if (n == 8'hFF) begin
                            blk       <= blk + 3'd1;
                            n         <= '0;
                            acc       <= '0;
                            last_sent <= (blk == 3'(NBLK-1));
                        end else begin
                            n   <= n_inc;
                            acc <= acc_step;
                        end
                    end
                end
                FLUSH: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    sram_cen <= 1'b1;
                    sram_wen <= 1'b1;
                    done     <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_da_lut_loader.sv
// Bench for da_lut_loader: behavioural sram_8blk write model, scoreboard of expected writes,
// table-driven read-back checks and hand-written protocol/reset sequences.
module tb_da_lut_loader;

    localparam int CW   = 16;
    localparam int DW   = 20;
    localparam int NBLK = 8;
    localparam int NENT = NBLK * 256;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coef_we = 1'b0;
    logic [5:0]    coef_idx = '0;
    logic [CW-1:0] coef_din = '0;
    logic          start = 1'b0;
    logic          busy, done, sram_wen, sram_cen;
    logic [DW-1:0] sram_d;
    logic [10:0]   sram_caddr;
`ifdef LUT_CHECKSUM_EN
    logic [DW-1:0] checksum;
`endif

    da_lut_loader #(.CW(CW), .DW(DW), .NBLK(NBLK)) dut (
        .clk        (clk),
        .rst        (rst),
        .coef_we    (coef_we),
        .coef_idx   (coef_idx),
        .coef_din   (coef_din),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .sram_d     (sram_d),
        .sram_caddr (sram_caddr),
        .sram_wen   (sram_wen),
        .sram_cen   (sram_cen)
`ifdef LUT_CHECKSUM_EN
        ,
        .checksum   (checksum)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [10:0]   caddr;
        logic [DW-1:0] d;
    } wr_t;

    typedef struct {
        int            blk;
        int            addr;
        logic [DW-1:0] exp;
    } rb_t;

    wr_t           sb[$];
    logic [CW-1:0] cm [64];
    logic [DW-1:0] mem [NENT];
    logic [10:0]   caddr_q;
    logic [DW-1:0] d_q;
    logic          mem_clear = 1'b0;
    int            n_checks = 0;
    int            n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // sram_8blk write side: CADDR/D registered on posedge, WEN/CEN used combinationally.
    always @(posedge clk) begin
        caddr_q <= sram_caddr;
        d_q     <= sram_d;
    end

    always @(negedge clk) begin
        wr_t e;
        if (mem_clear) begin
            for (int i = 0; i < NENT; i++) mem[i] <= 20'h5A5A5;
        end else if (!rst && !sram_wen && !sram_cen) begin
            mem[caddr_q] <= d_q;
            if (sb.size() == 0) begin
                check("unexpected_write", 32'(caddr_q), 32'hFFFF);
            end else begin
                e = sb.pop_front();
                check("wr_caddr", 32'(caddr_q), 32'(e.caddr));
                check("wr_data", 32'(d_q), 32'(e.d));
            end
        end
    end

    function automatic logic [DW-1:0] lut(input int b, input int a);
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < 8; k++) begin
            if (a[k]) s = s + {{(DW-CW){cm[8*b+k][CW-1]}}, cm[8*b+k]};
        end
        return s;
    endfunction

    task automatic push_all();
        wr_t e;
        int  g;
        for (int b = 0; b < NBLK; b++) begin
            for (int n = 0; n < 256; n++) begin
                g       = n ^ (n >> 1);
                e.caddr = 11'(b * 256 + g);
                e.d     = lut(b, g);
                sb.push_back(e);
            end
        end
    endtask

    task automatic prog(input int idx, input logic [CW-1:0] v);
        @(negedge clk);
        coef_we  = 1'b1;
        coef_idx = 6'(idx);
        coef_din = v;
        cm[idx]  = v;
        @(negedge clk);
        coef_we  = 1'b0;
    endtask

    task automatic clear_mem();
        @(negedge clk);
        mem_clear = 1'b1;
        @(negedge clk);
        #1 mem_clear = 1'b0;
    endtask

    task automatic run_load(input int inject_at, input bit same_write, input bit hold,
                            output int done_cyc, output int wen_cnt, output int done_cnt);
        int c;
        bit inj;
        done_cyc = -1;
        wen_cnt  = 0;
        done_cnt = 0;
        inj      = 1'b0;
        @(negedge clk);
        start = 1'b1;
        if (same_write) begin
            coef_we  = 1'b1;
            coef_idx = 6'd9;
            coef_din = cm[9] + 16'd1234;
            cm[9]    = coef_din;
        end
        push_all();
        @(posedge clk);
        @(negedge clk);
        coef_we = 1'b0;
        if (!hold) start = 1'b0;
        check("busy_after_e0", 32'(busy), 32'd0);
        c = 0;
        while (c < 3000 && (done_cyc < 0 || c < done_cyc + 4)) begin
            @(posedge clk);
            c++;
            @(negedge clk);
            if (inj) begin
                start   = 1'b0;
                coef_we = 1'b0;
                inj     = 1'b0;
            end
            if (c == 1) begin
                check("e1_busy", 32'(busy), 32'd1);
                check("e1_caddr", 32'(sram_caddr), 32'd0);
                check("e1_d", 32'(sram_d), 32'd0);
                check("e1_wen", 32'(sram_wen), 32'd1);
                check("e1_cen", 32'(sram_cen), 32'd0);
            end
            if (!sram_wen) wen_cnt++;
            if (done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end else if (done_cyc > 0) begin
                check("no_restart_busy", 32'(busy), 32'd0);
            end
            if (c == inject_at) begin
                start    = 1'b1;
                coef_we  = 1'b1;
                coef_idx = 6'd5;
                coef_din = ~cm[5];
                inj      = 1'b1;
            end
        end
        start = 1'b0;
        if (done_cyc < 0) check("done_timeout", 32'd0, 32'd1);
    endtask

    task automatic check_load(input string tag, input int done_cyc, input int wen_cnt, input int done_cnt);
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(NENT + 2));
        check({tag, "_wen_low_cycles"}, 32'(wen_cnt), 32'(NENT));
        check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
        check({tag, "_sb_drained"}, 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rb_t pow_tbl[8];
        rb_t neg_tbl[9];
        int  dc, wc, pc, c;

        pow_tbl[0] = '{0, 8'h00, 20'h00000};
        pow_tbl[1] = '{0, 8'h01, 20'h00001};
        pow_tbl[2] = '{0, 8'h80, 20'h00080};
        pow_tbl[3] = '{0, 8'hFF, 20'h000FF};
        pow_tbl[4] = '{0, 8'h55, 20'h00055};
        pow_tbl[5] = '{1, 8'hFF, 20'h00000};
        pow_tbl[6] = '{7, 8'h3C, 20'h00000};
        pow_tbl[7] = '{4, 8'h01, 20'h00000};
        neg_tbl[0] = '{0, 8'hFF, 20'hC0000};
        neg_tbl[1] = '{0, 8'h01, 20'hF8000};
        neg_tbl[2] = '{0, 8'h00, 20'h00000};
        neg_tbl[3] = '{3, 8'hFF, 20'hC0000};
        neg_tbl[4] = '{3, 8'h01, 20'hF8000};
        neg_tbl[5] = '{3, 8'h00, 20'h00000};
        neg_tbl[6] = '{7, 8'hFF, 20'hC0000};
        neg_tbl[7] = '{7, 8'h01, 20'hF8000};
        neg_tbl[8] = '{7, 8'h03, 20'hF0000};

        for (int i = 0; i < 64; i++) cm[i] = '0;

        // Reset values.
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(sram_d), 32'd0);
        check("rst_caddr", 32'(sram_caddr), 32'd0);
        check("rst_wen", 32'(sram_wen), 32'd1);
        check("rst_cen", 32'(sram_cen), 32'd1);
`ifdef LUT_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        // Power-of-two taps in block 0.
        for (int k = 0; k < 8; k++) prog(k, 16'(1 << k));
        clear_mem();
        run_load(-1, 1'b0, 1'b0, dc, wc, pc);
        check_load("pow2", dc, wc, pc);
`ifdef LUT_CHECKSUM_EN
        check("pow2_checksum", 32'(checksum), 32'h07F80);
`endif
        for (int i = 0; i < 8; i++)
            check("pow2_readback", 32'(mem[pow_tbl[i].blk * 256 + pow_tbl[i].addr]), 32'(pow_tbl[i].exp));

        // Negative extreme on every tap.
        for (int i = 0; i < 64; i++) prog(i, 16'h8000);
        clear_mem();
        run_load(-1, 1'b0, 1'b0, dc, wc, pc);
        check_load("neg", dc, wc, pc);
        for (int i = 0; i < 9; i++)
            check("neg_readback", 32'(mem[neg_tbl[i].blk * 256 + neg_tbl[i].addr]), 32'(neg_tbl[i].exp));

        // start and coef_we during LOAD are dropped.
        for (int i = 0; i < 64; i++) prog(i, 16'($urandom));
        run_load(100, 1'b0, 1'b0, dc, wc, pc);
        check_load("protocol", dc, wc, pc);

        // Same-cycle coef_we with start, start held high for the whole load.
        run_load(-1, 1'b1, 1'b1, dc, wc, pc);
        check_load("samecyc_hold", dc, wc, pc);

        // Asynchronous reset mid-load at caddr 0x2BC.
        @(negedge clk);
        start = 1'b1;
        push_all();
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        c = 0;
        while (c < 3000 && !(busy && sram_caddr == 11'h2BC)) begin
            @(negedge clk);
            c++;
        end
        check("reach_2bc", 32'(sram_caddr), 32'h2BC);
        #2 rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 64; i++) cm[i] = '0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_wen", 32'(sram_wen), 32'd1);
        check("midrst_cen", 32'(sram_cen), 32'd1);
        check("midrst_caddr", 32'(sram_caddr), 32'd0);
        check("midrst_d", 32'(sram_d), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("postrst_done", 32'(done), 32'd0);
            check("postrst_busy", 32'(busy), 32'd0);
        end
        for (int i = 0; i < 64; i++) prog(i, 16'($urandom));
        clear_mem();
        run_load(-1, 1'b0, 1'b0, dc, wc, pc);
        check_load("reload", dc, wc, pc);
        for (int i = 0; i < NENT; i++)
            check("reload_readback", 32'(mem[i]), 32'(lut(i / 256, i % 256)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
